// File: rtl/mul_div_unit.sv
`default_nettype none
// ============================================================================
// Module   : mul_div_unit
// Purpose  : Iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers,
//            one bit per cycle (shift-add multiply, restoring divide).
//            Optional macro MDU_EARLY_OUT_EN: early multiply exit and
//            immediate divide-by-zero completion.
// Revision : 1.0  initial release
// ============================================================================
module mul_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic             cancel_i,
  input  logic [WIDTH-1:0] rs_data_i,
  input  logic [WIDTH-1:0] rt_data_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             div_zero_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int         c_CNT_W   = $clog2(WIDTH + 1);
  localparam logic [1:0] c_ST_IDLE = 2'd0;
  localparam logic [1:0] c_ST_RUN  = 2'd1;
  localparam logic [1:0] c_ST_DONE = 2'd2;

  logic [1:0]         r_state;
  logic [c_CNT_W-1:0] r_count;
  logic               r_is_div;
  logic               r_neg_q;
  logic               r_neg_r;
  logic               r_div_zero;
  logic [WIDTH-1:0]   r_rs_raw;
  // Multiply: r_acc = partial product, r_x = shifted multiplicand, r_y = multiplier.
  // Divide:   r_acc[WIDTH-1:0] = remainder, r_x[WIDTH-1:0] = divisor, r_y = dividend/quotient.
  logic [2*WIDTH-1:0] r_acc;
  logic [2*WIDTH-1:0] r_x;
  logic [WIDTH-1:0]   r_y;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;

  logic               w_start;
  logic               w_rs_neg;
  logic               w_rt_neg;
  logic [WIDTH-1:0]   w_rs_mag;
  logic [WIDTH-1:0]   w_rt_mag;
  logic [2*WIDTH-1:0] w_mul_acc;
  logic [WIDTH-1:0]   w_y_mul;
  logic [WIDTH:0]     w_trial;
  logic               w_ge;
  logic [WIDTH-1:0]   w_rem_next;
  logic [WIDTH-1:0]   w_quo_next;
  logic [2*WIDTH-1:0] w_prod_s;
  logic [WIDTH-1:0]   w_hi_res;
  logic [WIDTH-1:0]   w_lo_res;
  logic               w_last;

  assign w_start  = start_i & ~cancel_i;
  assign w_rs_neg = op_i[0] & rs_data_i[WIDTH-1];
  assign w_rt_neg = op_i[0] & rt_data_i[WIDTH-1];
  assign w_rs_mag = w_rs_neg ? -rs_data_i : rs_data_i;
  assign w_rt_mag = w_rt_neg ? -rt_data_i : rt_data_i;

  assign w_mul_acc = r_y[0] ? (r_acc + r_x) : r_acc;
  assign w_y_mul   = r_y >> 1;

  // Restoring step: bring in the next dividend bit and try to subtract.
  assign w_trial    = {r_acc[WIDTH-1:0], r_y[WIDTH-1]} - {1'b0, r_x[WIDTH-1:0]};
  assign w_ge       = ~w_trial[WIDTH];
  assign w_rem_next = w_ge ? w_trial[WIDTH-1:0] : {r_acc[WIDTH-2:0], r_y[WIDTH-1]};
  assign w_quo_next = {r_y[WIDTH-2:0], w_ge};

  assign w_prod_s = r_neg_q ? -w_mul_acc : w_mul_acc;

`ifdef MDU_EARLY_OUT_EN
  assign w_last = (r_count == c_CNT_W'(1)) || (!r_is_div && (w_y_mul == '0));
`else
  assign w_last = (r_count == c_CNT_W'(1));
`endif

  always_comb begin
    w_hi_res = w_prod_s[2*WIDTH-1:WIDTH];
    w_lo_res = w_prod_s[WIDTH-1:0];
    if (r_is_div) begin
      if (r_div_zero) begin
        w_hi_res = r_rs_raw;
        w_lo_res = '1;
      end else begin
        w_hi_res = r_neg_r ? -w_rem_next : w_rem_next;
        w_lo_res = r_neg_q ? -w_quo_next : w_quo_next;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state    <= c_ST_IDLE;
      r_count    <= '0;
      r_is_div   <= 1'b0;
      r_neg_q    <= 1'b0;
      r_neg_r    <= 1'b0;
      r_div_zero <= 1'b0;
      r_rs_raw   <= '0;
      r_acc      <= '0;
      r_x        <= '0;
      r_y        <= '0;
      r_hi       <= '0;
      r_lo       <= '0;
    end else begin
      case (r_state)
        c_ST_IDLE: begin
          if (w_start) begin
            r_state    <= c_ST_RUN;
            r_count    <= c_CNT_W'(WIDTH);
            r_is_div   <= op_i[1];
            r_neg_q    <= w_rs_neg ^ w_rt_neg;
            r_neg_r    <= w_rs_neg;
            r_div_zero <= op_i[1] & (rt_data_i == '0);
            r_rs_raw   <= rs_data_i;
            r_acc      <= '0;
            r_x        <= {{WIDTH{1'b0}}, (op_i[1] ? w_rt_mag : w_rs_mag)};
            r_y        <= op_i[1] ? w_rs_mag : w_rt_mag;
`ifdef MDU_EARLY_OUT_EN
            if (op_i[1] && (rt_data_i == '0)) begin
              r_state <= c_ST_DONE;
              r_hi    <= rs_data_i;
              r_lo    <= '1;
            end
`endif
          end
        end
        c_ST_RUN: begin
          if (cancel_i) begin
            r_state <= c_ST_IDLE;
          end else begin
            r_count <= r_count - c_CNT_W'(1);
            if (r_is_div) begin
              r_acc <= {{WIDTH{1'b0}}, w_rem_next};
              r_y   <= w_quo_next;
            end else begin
              r_acc <= w_mul_acc;
              r_x   <= r_x << 1;
              r_y   <= w_y_mul;
            end
            if (w_last) begin
              r_state <= c_ST_DONE;
              r_hi    <= w_hi_res;
              r_lo    <= w_lo_res;
            end
          end
        end
        c_ST_DONE: r_state <= c_ST_IDLE;
        default:   r_state <= c_ST_IDLE;
      endcase
    end
  end

  assign busy_o     = (r_state == c_ST_RUN);
  assign done_o     = (r_state == c_ST_DONE);
  assign div_zero_o = (r_state == c_ST_DONE) & r_div_zero;
  assign hi_o       = r_hi;
  assign lo_o       = r_lo;

endmodule
`default_nettype wire

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
- Iterative multiply/divide unit with HI/LO result registers for the next-generation MIPS datapath; serves MULT, MULTU, DIV and DIVU.
- Sits beside the ALU in the EX stage. The CPU top launches an operation with start_i, stalls on busy_o, and reads hi_o/lo_o for MFHI/MFLO.
- Radix-2 shift-add multiply and restoring divide, one bit per cycle, generalised to WIDTH bits. Pipeline flush is supported.

Parameters:
- WIDTH, 32, operand and HI/LO width in bits (legal range 4 to 64).

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- start_i  in  1  launch request; sampled only in IDLE.
- op_i  in  2  operation: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
- cancel_i  in  1  flush: abort the in-flight operation.
- rs_data_i  in  WIDTH  multiplicand / dividend.
- rt_data_i  in  WIDTH  multiplier / divisor.
- busy_o  out  1  operation in flight.
- done_o  out  1  one-cycle pulse when HI/LO are updated.
- div_zero_o  out  1  the completed operation was a divide by zero; valid while done_o is high.
- hi_o  out  WIDTH  HI register: upper product half or remainder.
- lo_o  out  WIDTH  LO register: lower product half or quotient.

Behaviour:
- Reset (asynchronous, at any time, including mid-operation):
  - state goes to IDLE; busy_o, done_o and div_zero_o go to 0; hi_o and lo_o go to 0.
  - Any in-flight operation is discarded.
- States: IDLE, RUN, DONE.
- IDLE:
  - start_i=1 and cancel_i=0 at edge E0: operands and op are latched and the state moves to RUN.
  - Signed ops store magnitudes and record the result sign, with quotient sign = sign(rs) XOR sign(rt) and remainder sign = sign(rs).
  - The iteration counter is loaded with WIDTH.
  - start_i=1 together with cancel_i=1 is ignored.
- RUN:
  - One iteration per edge; the counter decrements each edge.
  - After WIDTH iterations (edge E0+WIDTH) the state moves to DONE.
- DONE:
  - Lasts exactly one cycle. At entry to DONE (edge E0+WIDTH), hi_o/lo_o load the sign-corrected result, and done_o and div_zero_o become valid.
  - At the next edge the state returns to IDLE and done_o clears.
  - Total latency: done_o is high in the cycle after edge E0+WIDTH.
- busy_o is high exactly while the state is RUN; it is low in IDLE and DONE.
- start_i asserted during RUN or DONE is ignored; it is not queued.
- cancel_i in RUN: the state returns to IDLE at the next edge; hi_o/lo_o keep their previous values; no done_o pulse is produced.
- cancel_i in DONE has no effect, because the result is already committed.
- Multiply: {hi_o,lo_o} is the full 2*WIDTH-bit product. MULT is two's-complement; MULTU is unsigned.
- Divide: lo_o is the quotient truncated toward zero; hi_o is the remainder, with the sign of the dividend.
- Divide by zero (either signedness):
  - lo_o = all ones; hi_o = rs_data as latched; div_zero_o = 1.
  - Latency is normal unless the optional feature is enabled.
- Signed overflow (DIV of the most-negative value by -1): lo_o = most-negative value, hi_o = 0, div_zero_o = 0.
- hi_o/lo_o are written only at DONE; they are stable at all other times.

Optional Feature:
- Macro: MDU_EARLY_OUT_EN.
- Enabled:
  - Multiply leaves RUN as soon as the remaining multiplier bits are all zero. The product is unaffected; latency becomes 1 + the index of the highest set bit of the multiplier magnitude, with a minimum of 1.
  - Divide by zero goes straight from IDLE to DONE, so done_o is high in the cycle after E0.
- Disabled: every operation takes the fixed WIDTH-cycle latency.

Test Plan:
- Fixed latency: reset, then MULTU rs=0xFFFFFFFF rt=0xFFFFFFFF (WIDTH=32) -> busy_o high for 32 cycles; done_o high in the cycle after edge E0+32; hi_o=0xFFFFFFFE, lo_o=0x00000001.
- Signed multiply: MULT rs=-7 rt=3 -> hi_o=0xFFFFFFFF, lo_o=0xFFFFFFEB.
- Signed divide with overflow case:
  - DIV rs=-7 rt=2 -> lo_o=0xFFFFFFFD, hi_o=0xFFFFFFFF.
  - DIV rs=0x80000000 rt=0xFFFFFFFF -> lo_o=0x80000000, hi_o=0, div_zero_o=0.
- Divide by zero: DIVU rs=0x1234 rt=0 -> lo_o=0xFFFFFFFF, hi_o=0x1234, div_zero_o=1 for one cycle. With MDU_EARLY_OUT_EN, done_o is high in the cycle after E0.
- Cancel and ignored start: launch DIVU 100/7 after a prior result HI=5, LO=9, then assert cancel_i at cycle 10 -> IDLE next cycle, no done_o, hi_o=5, lo_o=9. A start_i during RUN is ignored; start_i together with cancel_i in IDLE launches nothing.
- Mid-operation reset: assert rst_i asynchronously in RUN between edges -> busy_o, hi_o and lo_o drop to 0 immediately; the next start_i proceeds with normal latency.
